// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the eight-way round-robin arbiter:
//   - arb_state_e   : arbiter state (IDLE = no grant, BUSY = grant held)
//   - DEFAULT_N     : requester count expected by the downstream encoder
//   - DEFAULT_IDX_W : index width for DEFAULT_N requesters
//   - holdWidth()   : width of a counter able to reach maxHold
// ---------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int DEFAULT_N     = 8;
    localparam int DEFAULT_IDX_W = $clog2(DEFAULT_N);

    // A disabled hold limit (0) still needs a one-bit counter so that the
    // register declaration stays legal; the counter is simply never advanced.
    function automatic int holdWidth(input int maxHold);
        if (maxHold < 1) begin
            return 1;
        end
        return $clog2(maxHold + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner search. The search starts at ptr_i and
// wraps upward; the first set request bit wins.
// Ports:
//   req_i     [N]  : request vector
//   ptr_i     [IW] : highest-priority index for this search
//   win_o     [N]  : one-hot winner, all-zero when nothing requests
//   win_idx_o [IW] : binary index of the winner (0 when nothing requests)
//   any_o          : high when at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  win_o,
    output logic [IW-1:0] win_idx_o,
    output logic          any_o
);

    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl;

    // Lower half holds only the requests at or above the pointer; upper half
    // holds the full vector. The lowest set bit of the concatenation is the
    // wrapped round-robin winner, so a single priority scan is enough.
    assign mask  = {N{1'b1}} << ptr_i;
    assign dbl   = {req_i, req_i & mask};
    assign any_o = |req_i;

    // Scan from the top down so the last hit is the lowest set bit.
    always_comb begin
        win_idx_o = '0;
        for (int i = 2 * N - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                win_idx_o = IW'(i % N);
            end
        end
    end

    assign win_o = any_o ? (N'(1) << win_idx_o) : '0;

endmodule

// File: rtl/rr_arbiter_8.sv
// ---------------------------------------------------------------------------
// rr_arbiter_8
// Eight-requester round-robin arbiter with grant hold and optional hold-limit
// preemption. The grant vector is registered and is always one-hot or zero,
// so it can feed an 8-to-3 encoder directly.
// Ports:
//   clk_i         : clock, rising edge
//   rst_i         : synchronous active-high reset
//   req_i     [N] : level-sensitive request lines
//   done_i        : current holder releases the grant (ignored when idle)
//   gnt_o     [N] : registered one-hot grant
//   gnt_valid_o   : registered, high iff gnt_o is non-zero
//   preempt_o     : registered one-cycle pulse on a hold-limit revocation
// ---------------------------------------------------------------------------
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int MAX_HOLD = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         done_i,
    output logic [N-1:0] gnt_o,
    output logic         gnt_valid_o,
    output logic         preempt_o
);

    localparam int IW = $clog2(N);
    localparam int HW = holdWidth(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

    arb_state_e    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic          preempt_q, preempt_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [IW-1:0] nextPtr;
    logic [IW-1:0] pickPtr;
    logic [N-1:0]  pickWin;
    logic [IW-1:0] pickIdx;
    logic          pickAny;
    logic          holderReq;
    logic          limitHit;
    logic          releaseEvt;

    // The slot after the current holder; the holder becomes lowest priority.
    assign nextPtr = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;

    // While busy the search must already use the post-release pointer so that
    // the replacement grant lands in the same cycle as the release.
    assign pickPtr = (state_q == BUSY) ? nextPtr : ptr_q;

    // hold_q counts cycles already spent beyond the first, so reaching
    // HOLD_LAST means the holder has now seen the grant MAX_HOLD times.
    assign holderReq  = req_i[idx_q];
    assign limitHit   = (MAX_HOLD > 0) && (hold_q == HOLD_LAST);
    assign releaseEvt = done_i || !holderReq || limitHit;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req_i     (req_i),
        .ptr_i     (pickPtr),
        .win_o     (pickWin),
        .win_idx_o (pickIdx),
        .any_o     (pickAny)
    );

    // Next-state logic: grant from IDLE, or on a release move the pointer past
    // the holder and hand the grant straight to the next winner.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        preempt_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pickAny) begin
                    gnt_d   = pickWin;
                    idx_d   = pickIdx;
                    hold_d  = '0;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                if (releaseEvt) begin
                    ptr_d     = nextPtr;
                    // A voluntary release in the same cycle wins over the limit.
                    preempt_d = limitHit && !done_i && holderReq;
                    hold_d    = '0;
                    if (pickAny) begin
                        gnt_d = pickWin;
                        idx_d = pickIdx;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (MAX_HOLD > 0) begin
                    hold_d = hold_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        gnt_valid_d = |gnt_d;
    end

    // State and output registers; reset clears everything, including any
    // pending preempt pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
            ptr_q       <= '0;
            idx_q       <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = gnt_valid_q;
    assign preempt_o   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_8
// Directed bench for rr_arbiter_8 built with a hold limit of 4 cycles.
// Inputs are driven and outputs sampled 1ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       gntValid;
    logic       preempt;

    int checkCount;
    int errorCount;

    rr_arbiter_8 #(
        .N        (8),
        .MAX_HOLD (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .done_i      (done),
        .gnt_o       (gnt),
        .gnt_valid_o (gntValid),
        .preempt_o   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a new input pattern for the coming edge.
    task automatic applyStimulus(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
    endtask

    // Two-cycle reset leaving the pointer at 0 and inputs quiet.
    task automatic doReset();
        rst = 1'b1;
        applyStimulus(8'h00, 1'b0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        checkCount++;
        if ({gnt, gntValid, preempt} !== 10'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_outputs: got gnt=%h valid=%b preempt=%b, expected all 0", gnt, gntValid, preempt);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checkCount++;
            if (gnt !== 8'h00 || gntValid !== 1'b0) begin
                errorCount++;
                $display("[TB] FAIL idle_no_req cycle %0d: got gnt=%h valid=%b, expected 00/0", i, gnt, gntValid);
            end
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        applyStimulus(8'h81, 1'b0);
        step();
        checkCount++;
        if (gnt !== 8'h01 || gntValid !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL b2b_first: got gnt=%h valid=%b, expected 01/1", gnt, gntValid);
        end
        applyStimulus(8'h81, 1'b1);
        step();
        checkCount++;
        if (gnt !== 8'h80 || gntValid !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL b2b_second: got gnt=%h valid=%b, expected 80/1", gnt, gntValid);
        end
        step();
        checkCount++;
        if (gnt !== 8'h01) begin
            errorCount++;
            $display("[TB] FAIL b2b_wrap_ptr0: got gnt=%h, expected 01", gnt);
        end
        applyStimulus(8'h00, 1'b0);
        step();
        checkCount++;
        if (gnt !== 8'h00 || gntValid !== 1'b0 || preempt !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL b2b_to_idle: got gnt=%h valid=%b preempt=%b, expected 00/0/0", gnt, gntValid, preempt);
        end
    endtask

    task automatic test_walk();
        logic [7:0] expGnt;
        doReset();
        applyStimulus(8'hFF, 1'b1);
        expGnt = 8'h01;
        for (int i = 0; i < 9; i++) begin
            step();
            checkCount++;
            if (gnt !== expGnt || gntValid !== 1'b1 || preempt !== 1'b0) begin
                errorCount++;
                $display("[TB] FAIL walk step %0d: got gnt=%h valid=%b preempt=%b, expected %h/1/0", i, gnt, gntValid, preempt, expGnt);
            end
            expGnt = {expGnt[6:0], expGnt[7]};
        end
        applyStimulus(8'h00, 1'b0);
        step();
    endtask

    task automatic test_hold_limit();
        logic [7:0] expGnt [13];
        logic       expPre [13];
        expGnt = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h08, 8'h08, 8'h08, 8'h08,
                   8'h04, 8'h04, 8'h04, 8'h04, 8'h08};
        expPre = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        doReset();
        applyStimulus(8'h0C, 1'b0);
        for (int i = 0; i < 13; i++) begin
            // On the final step the limit and a done coincide; done must win.
            if (i == 12) begin
                applyStimulus(8'h0C, 1'b1);
            end
            step();
            checkCount++;
            if (gnt !== expGnt[i] || preempt !== expPre[i]) begin
                errorCount++;
                $display("[TB] FAIL hold_limit step %0d: got gnt=%h preempt=%b, expected %h/%b", i, gnt, preempt, expGnt[i], expPre[i]);
            end
        end
    endtask

    task automatic test_req_drop();
        // Holder 3 is granted at the end of test_hold_limit.
        applyStimulus(8'h00, 1'b0);
        step();
        checkCount++;
        if (gnt !== 8'h00 || gntValid !== 1'b0 || preempt !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL req_drop_idle: got gnt=%h valid=%b preempt=%b, expected 00/0/0", gnt, gntValid, preempt);
        end
        applyStimulus(8'h01, 1'b0);
        step();
        checkCount++;
        if (gnt !== 8'h01 || gntValid !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL req_drop_regrant: got gnt=%h valid=%b, expected 01/1", gnt, gntValid);
        end
        applyStimulus(8'h00, 1'b0);
        step();
    endtask

    task automatic test_single_bit();
        logic [7:0] oneHot;
        for (int k = 7; k >= 0; k -= 3) begin
            oneHot = 8'h01 << k;
            applyStimulus(oneHot, 1'b0);
            step();
            checkCount++;
            if (gnt !== oneHot) begin
                errorCount++;
                $display("[TB] FAIL single_bit k=%0d: got gnt=%h, expected %h", k, gnt, oneHot);
            end
            applyStimulus(8'h00, 1'b0);
            step();
        end
    endtask

    task automatic test_reset_busy();
        doReset();
        applyStimulus(8'h20, 1'b0);
        step();
        checkCount++;
        if (gnt !== 8'h20) begin
            errorCount++;
            $display("[TB] FAIL rst_busy_setup: got gnt=%h, expected 20", gnt);
        end
        applyStimulus(8'h21, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkCount++;
        if ({gnt, gntValid, preempt} !== 10'b0) begin
            errorCount++;
            $display("[TB] FAIL rst_busy_clear: got gnt=%h valid=%b preempt=%b, expected all 0", gnt, gntValid, preempt);
        end
        step();
        checkCount++;
        if (gnt !== 8'h01 || gntValid !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL rst_busy_ptr0: got gnt=%h valid=%b, expected 01/1", gnt, gntValid);
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        $display("[TB] rr_arbiter_8 directed bench");
        test_reset();
        test_back_to_back();
        test_walk();
        test_hold_limit();
        test_req_drop();
        test_single_bit();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
